// File: rtl/qsys_system_pio_out_ext.sv
// qsys_system_pio_out_ext: parametrised Avalon-MM output PIO (s1 slave, read latency 0).
// Registers: DATA, OUTSET, OUTCLR, self-clearing PULSE, and optional blink engine.
// Optional feature macro: PIO_OUT_BLINK_EN enables BLINK_MASK / BLINK_PERIOD and the blink engine.
module qsys_system_pio_out_ext #(
    parameter int unsigned WIDTH        = 10,
    parameter int unsigned PULSE_CYCLES = 50000000,
    parameter int unsigned PERIOD_W     = 32,
    parameter logic [31:0] RESET_VALUE  = 32'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    // Pulse counter only needs to hold PULSE_CYCLES-1.
    localparam int unsigned PCW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [PCW-1:0] PULSE_RELOAD = PCW'(PULSE_CYCLES - 1);
    localparam logic [WIDTH-1:0] DATA_RST = RESET_VALUE[WIDTH-1:0];

    logic             wr_s;
    logic [WIDTH-1:0] wd_s;
    logic             pulse_wr_s;
    logic             unused_s;

    logic [WIDTH-1:0] data_q,  data_d;
    logic [WIDTH-1:0] pulse_q, pulse_d;
    logic [PCW-1:0]   pcnt_q,  pcnt_d;

    assign wr_s       = chipselect & ~write_n;
    assign wd_s       = writedata[WIDTH-1:0];
    // A PULSE write whose in-range data is zero must not reload the counter.
    assign pulse_wr_s = wr_s && (address == 3'd4) && (wd_s != {WIDTH{1'b0}});
    assign unused_s   = ^writedata;

    // DATA next-state: direct write, atomic set, atomic clear.
    always_comb begin
        data_d = data_q;
        if (wr_s) begin
            case (address)
                3'd0:    data_d = wd_s;
                3'd2:    data_d = data_q | wd_s;
                3'd3:    data_d = data_q & ~wd_s;
                default: data_d = data_q;
            endcase
        end else begin
            data_d = data_q;
        end
    end

    // PULSE next-state: a write (even in the expiry cycle) wins over the self-clear.
    always_comb begin
        pulse_d = pulse_q;
        pcnt_d  = pcnt_q;
        if (pulse_wr_s) begin
            pulse_d = pulse_q | wd_s;
            pcnt_d  = PULSE_RELOAD;
        end else if (pulse_q != {WIDTH{1'b0}}) begin
            if (pcnt_q == {PCW{1'b0}}) begin
                pulse_d = {WIDTH{1'b0}};
                pcnt_d  = {PCW{1'b0}};
            end else begin
                pcnt_d  = pcnt_q - PCW'(1'b1);
            end
        end else begin
            pcnt_d  = {PCW{1'b0}};
        end
    end

    // DATA and PULSE state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= DATA_RST;
            pulse_q <= {WIDTH{1'b0}};
            pcnt_q  <= {PCW{1'b0}};
        end else begin
            data_q  <= data_d;
            pulse_q <= pulse_d;
            pcnt_q  <= pcnt_d;
        end
    end

`ifdef PIO_OUT_BLINK_EN
    logic [WIDTH-1:0]    mask_q,   mask_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] bcnt_q,   bcnt_d;
    logic                phase_q,  phase_d;

    // Blink next-state: period write restarts at phase 0; period 0 holds the engine idle.
    always_comb begin
        mask_d   = mask_q;
        period_d = period_q;
        bcnt_d   = bcnt_q;
        phase_d  = phase_q;
        if (wr_s && (address == 3'd5)) begin
            mask_d = wd_s;
        end else begin
            mask_d = mask_q;
        end
        if (wr_s && (address == 3'd6)) begin
            period_d = writedata[PERIOD_W-1:0];
            bcnt_d   = {PERIOD_W{1'b0}};
            phase_d  = 1'b0;
        end else if (period_q == {PERIOD_W{1'b0}}) begin
            bcnt_d   = {PERIOD_W{1'b0}};
            phase_d  = 1'b0;
        end else if (bcnt_q == (period_q - PERIOD_W'(1'b1))) begin
            bcnt_d   = {PERIOD_W{1'b0}};
            phase_d  = ~phase_q;
        end else begin
            bcnt_d   = bcnt_q + PERIOD_W'(1'b1);
        end
    end

    // Blink engine state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q   <= {WIDTH{1'b0}};
            period_q <= {PERIOD_W{1'b0}};
            bcnt_q   <= {PERIOD_W{1'b0}};
            phase_q  <= 1'b0;
        end else begin
            mask_q   <= mask_d;
            period_q <= period_d;
            bcnt_q   <= bcnt_d;
            phase_q  <= phase_d;
        end
    end

    // Blink blanks masked bits over both DATA and PULSE.
    assign out_port = (data_q | pulse_q) & ~(mask_q & {WIDTH{phase_q}});
`else
    assign out_port = data_q | pulse_q;
`endif

    // Zero-latency read mux; write-only and reserved addresses read 0.
    always_comb begin
        readdata = 32'd0;
        case (address)
            3'd0:    readdata = 32'(data_q);
            3'd4:    readdata = 32'(pulse_q);
`ifdef PIO_OUT_BLINK_EN
            3'd5:    readdata = 32'(mask_q);
            3'd6:    readdata = 32'(period_q);
`endif
            default: readdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_qsys_system_pio_out_ext.sv
// Scoreboard bench for qsys_system_pio_out_ext (WIDTH=10, PULSE_CYCLES=4, RESET_VALUE=0x155).
// Blink checks run when PIO_OUT_BLINK_EN is defined, otherwise the disabled-address checks run.
module tb_qsys_system_pio_out_ext;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [9:0]  out_port;

    qsys_system_pio_out_ext #(
        .WIDTH(10), .PULSE_CYCLES(4), .PERIOD_W(8), .RESET_VALUE(32'h155)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );

    typedef struct packed {
        logic        co;
        logic [9:0]  eo;
        logic        cr;
        logic [31:0] er;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_mis = 0;
    event  async_ev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [9:0] eo, input logic cr, input logic [31:0] er, input string nm);
        exp_t e;
        e.co = 1'b1; e.eo = eo; e.cr = cr; e.er = er;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic do_check();
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.co) begin
            n_cmp++;
            if (out_port !== e.eo) begin
                n_mis++;
                $display("FAIL %s out_port got %h want %h", nm, out_port, e.eo);
            end
        end
        if (e.cr) begin
            n_cmp++;
            if (readdata !== e.er) begin
                n_mis++;
                $display("FAIL %s readdata got %h want %h", nm, readdata, e.er);
            end
        end
    endtask

    // Monitor: state after each edge is compared one step after the edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) do_check();
    end

    // Monitor for asynchronous (between-edge) checks.
    initial begin
        forever begin
            @(async_ev);
            if (exp_q.size() > 0) do_check();
        end
    end

    // One bus cycle; expectation is the state after the following edge.
    task automatic step(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd,
                        input logic [9:0] eo, input logic [31:0] er, input string nm);
        @(negedge clk);
        chipselect = cs; write_n = wn; address = a; writedata = wd;
        push(eo, 1'b1, er, nm);
    endtask

    task automatic idle(input logic [2:0] a, input logic [9:0] eo, input logic [31:0] er, input string nm);
        step(1'b0, 1'b1, a, 32'd0, eo, er, nm);
    endtask

    task automatic async_chk(input logic [2:0] a, input logic [9:0] eo, input logic [31:0] er, input string nm);
        address = a;
        #1;
        push(eo, 1'b1, er, nm);
        -> async_ev;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        for (int a = 0; a < 8; a++) begin
            async_chk(3'(a), 10'h155, (a == 0) ? 32'h155 : 32'd0, $sformatf("rst_addr%0d", a));
        end
        @(negedge clk);
        reset = 1'b0;
        idle(3'd0, 10'h155, 32'h155, "rst_release");

        // DATA / OUTSET / OUTCLR and reserved address.
        step(1'b1, 1'b0, 3'd0, 32'h0F0, 10'h0F0, 32'h0F0, "wr_data");
        step(1'b1, 1'b0, 3'd2, 32'h003, 10'h0F3, 32'd0,   "wr_outset");
        step(1'b1, 1'b0, 3'd3, 32'h030, 10'h0C3, 32'd0,   "wr_outclr");
        idle(3'd0, 10'h0C3, 32'h0C3, "rd_data");
        idle(3'd2, 10'h0C3, 32'd0,   "rd_outset");
        step(1'b1, 1'b0, 3'd1, 32'hFFF, 10'h0C3, 32'd0,   "wr_rsv1");
        idle(3'd7, 10'h0C3, 32'd0,   "rd_rsv7");
        step(1'b1, 1'b0, 3'd0, 32'h000, 10'h000, 32'd0,   "clr_data");

        // Single pulse: high exactly 4 cycles.
        step(1'b1, 1'b0, 3'd4, 32'h001, 10'h001, 32'd1, "pulse_wr");
        for (int i = 0; i < 3; i++) idle(3'd4, 10'h001, 32'd1, $sformatf("pulse_hold%0d", i));
        idle(3'd4, 10'h000, 32'd0, "pulse_end");
        idle(3'd4, 10'h000, 32'd0, "pulse_idle");

        // Retrigger in the expiry cycle.
        step(1'b1, 1'b0, 3'd4, 32'h001, 10'h001, 32'd1, "retrig_wr1");
        for (int i = 0; i < 3; i++) idle(3'd4, 10'h001, 32'd1, $sformatf("retrig_a%0d", i));
        step(1'b1, 1'b0, 3'd4, 32'h002, 10'h003, 32'd3, "retrig_wr2");
        for (int i = 0; i < 3; i++) idle(3'd4, 10'h003, 32'd3, $sformatf("retrig_b%0d", i));
        idle(3'd4, 10'h000, 32'd0, "retrig_end");

        // Zero write is ignored, idle and mid-pulse.
        step(1'b1, 1'b0, 3'd4, 32'h000, 10'h000, 32'd0, "pulse_zero_idle");
        step(1'b1, 1'b0, 3'd4, 32'h004, 10'h004, 32'd4, "pz_wr");
        idle(3'd4, 10'h004, 32'd4, "pz_h0");
        step(1'b1, 1'b0, 3'd4, 32'h000, 10'h004, 32'd4, "pz_zero");
        idle(3'd4, 10'h004, 32'd4, "pz_h1");
        idle(3'd4, 10'h000, 32'd0, "pz_end");

        // DATA OR PULSE.
        step(1'b1, 1'b0, 3'd0, 32'h0AA, 10'h0AA, 32'h0AA, "mid_data");
        step(1'b1, 1'b0, 3'd4, 32'h101, 10'h1AB, 32'h101, "mid_pulse");

        // Asynchronous reset mid-pulse.
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        #1;
        reset = 1'b1;
        async_chk(3'd4, 10'h155, 32'd0,   "midrst_pulse");
        async_chk(3'd0, 10'h155, 32'h155, "midrst_data");
        @(negedge clk);
        reset = 1'b0;
        idle(3'd4, 10'h155, 32'd0, "midrst_after");
        idle(3'd0, 10'h155, 32'h155, "midrst_after_data");

`ifdef PIO_OUT_BLINK_EN
        step(1'b1, 1'b0, 3'd0, 32'h3FF, 10'h3FF, 32'h3FF, "bl_data");
        step(1'b1, 1'b0, 3'd5, 32'h00F, 10'h3FF, 32'h00F, "bl_mask");
        step(1'b1, 1'b0, 3'd6, 32'd3,   10'h3FF, 32'd3,   "bl_period");
        for (int i = 0; i < 2; i++) idle(3'd6, 10'h3FF, 32'd3, $sformatf("bl_on_a%0d", i));
        for (int i = 0; i < 3; i++) idle(3'd6, 10'h3F0, 32'd3, $sformatf("bl_off_a%0d", i));
        for (int i = 0; i < 3; i++) idle(3'd6, 10'h3FF, 32'd3, $sformatf("bl_on_b%0d", i));
        idle(3'd6, 10'h3F0, 32'd3, "bl_off_b");
        step(1'b1, 1'b0, 3'd6, 32'd3,   10'h3FF, 32'd3,   "bl_restart");
        for (int i = 0; i < 2; i++) idle(3'd6, 10'h3FF, 32'd3, $sformatf("bl_on_c%0d", i));
        idle(3'd6, 10'h3F0, 32'd3, "bl_off_c");
        step(1'b1, 1'b0, 3'd6, 32'd0,   10'h3FF, 32'd0,   "bl_period0");
        for (int i = 0; i < 4; i++) idle(3'd6, 10'h3FF, 32'd0, $sformatf("bl_steady%0d", i));
`else
        step(1'b1, 1'b0, 3'd5, 32'h0FF, 10'h155, 32'd0, "nobl_wr5");
        step(1'b1, 1'b0, 3'd6, 32'd2,   10'h155, 32'd0, "nobl_wr6");
        idle(3'd5, 10'h155, 32'd0, "nobl_rd5");
        for (int i = 0; i < 4; i++) idle(3'd6, 10'h155, 32'd0, $sformatf("nobl_rd6_%0d", i));
`endif

        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_mis++;
            $display("FAIL drain %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
